led_mode_ctrl: RTL and testbench

Parametrised LED mode controller, successor to the fixed 4-LED/2-switch mode display. It synchronises the slide switches and push buttons, debounces each button, and latches the display mode on a clean press edge. It drives an LED_W-wide thermometer pattern through one of four transforms, two of which are time-animated. It sits directly between board I/O pins and the LED pins at the top level.

---
 rtl/led_ctrl_pkg.sv | 24 ++
 rtl/led_mode_ctrl_btn_debounce.sv | 64 ++++++
 rtl/led_mode_ctrl.sv | 155 +++++++++++++++
 tb/tb_led_mode_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED mode controller: display modes and the
// saturating thermometer helper used to build the base pattern.
package led_ctrl_pkg;

  // Display modes, one per push button.
  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  localparam int NUM_BTN = 4;

  // One bit of a saturating thermometer mask: bit idx is set when it lies
  // below min(count, width). Evaluated per bit so any LED width works
  // without a fixed-width intermediate mask.
  function automatic logic therm_bit(input int unsigned count,
                                     input int unsigned width,
                                     input int unsigned idx);
    return (idx < count) && (idx < width);
  endfunction

endpackage

// File: rtl/led_mode_ctrl_btn_debounce.sv
// Single push-button front end: 2-flop synchroniser, stability counter and
// rising-edge detector on the debounced level.
module btn_debounce #(
  parameter int DEB_CYCLES = 1250000
) (
  input  logic clk_125,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES);

  logic             meta_reg;
  logic             sync_reg;
  logic             deb_reg;
  logic             deb_next;
  logic             deb_prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Two-flop synchroniser for the asynchronous button pin.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= btn;
      sync_reg <= meta_reg;
    end
  end

  // Count cycles of disagreement; the level flips once the synced value has
  // held its new state for the full debounce window, first differing cycle
  // included.
  always_comb begin
    cnt_next = '0;
    deb_next = deb_reg;
    if (sync_reg != deb_reg) begin
      if (cnt_reg == CNT_LAST) begin
        deb_next = sync_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Debounce state and previous level for edge detection.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      deb_reg      <= 1'b0;
      deb_prev_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      deb_reg      <= deb_next;
      deb_prev_reg <= deb_reg;
    end
  end

  assign press = deb_reg & ~deb_prev_reg;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED mode controller: switch-selected thermometer pattern shown through one
// of four button-selected transforms, two of them animated by a step timer.
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int LED_W       = 4,
  parameter int SW_W        = 2,
  parameter int DEB_CYCLES  = 1250000,
  parameter int STEP_CYCLES = 12500000
) (
  input  logic             clk_125,
  input  logic             rst_n,
  input  logic [SW_W-1:0]  sw,
  input  logic [3:0]       btn,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode
);

  localparam int STEP_W = $clog2(STEP_CYCLES);
  localparam int ROT_W  = $clog2(LED_W);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [ROT_W-1:0]  ROT_LAST  = ROT_W'(LED_W - 1);

  logic [SW_W-1:0]    sw_meta_reg;
  logic [SW_W-1:0]    sw_sync_reg;
  logic [NUM_BTN-1:0] press;
  mode_t              mode_reg;
  mode_t              mode_next;
  logic               restart;
  logic [STEP_W-1:0]  step_cnt_reg;
  logic [STEP_W-1:0]  step_cnt_next;
  logic [ROT_W-1:0]   rot_pos_reg;
  logic [ROT_W-1:0]   rot_pos_next;
  logic               phase_reg;
  logic               phase_next;
  logic               tick;
  logic [LED_W-1:0]   base;
  logic [LED_W-1:0]   rotated;
  int unsigned        rot_back;
  logic [LED_W-1:0]   led_reg;
  logic [LED_W-1:0]   led_next;

  // Switches are level inputs and only need synchronising, not debouncing.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= sw;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_debounce (
        .clk_125(clk_125),
        .rst_n  (rst_n),
        .btn    (btn[gi]),
        .press  (press[gi])
      );
    end
  endgenerate

  // Mode select: the highest-indexed press in a cycle wins; any press, even
  // of the current mode, restarts the animation timebase.
  always_comb begin
    mode_next = mode_reg;
    restart   = |press;
    for (int k = 0; k < NUM_BTN; k++) begin
      if (press[k]) begin
        mode_next = mode_t'(k[1:0]);
      end
    end
  end

  // Mode register.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg <= MODE_STATIC;
    end else begin
      mode_reg <= mode_next;
    end
  end

  assign tick = (step_cnt_reg == STEP_LAST);

  // Animation timebase; a restart overrides a coincident tick.
  always_comb begin
    step_cnt_next = step_cnt_reg + 1'b1;
    rot_pos_next  = rot_pos_reg;
    phase_next    = phase_reg;
    if (restart) begin
      step_cnt_next = '0;
      rot_pos_next  = '0;
      phase_next    = 1'b0;
    end else if (tick) begin
      step_cnt_next = '0;
      rot_pos_next  = (rot_pos_reg == ROT_LAST) ? '0 : rot_pos_reg + 1'b1;
      phase_next    = ~phase_reg;
    end
  end

  // Animation state registers.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_reg <= '0;
      rot_pos_reg  <= '0;
      phase_reg    <= 1'b0;
    end else begin
      step_cnt_reg <= step_cnt_next;
      rot_pos_reg  <= rot_pos_next;
      phase_reg    <= phase_next;
    end
  end

  // Base pattern: sw+1 low bits set, saturating at the LED width.
  generate
    for (gi = 0; gi < LED_W; gi++) begin : g_base
      assign base[gi] = therm_bit(32'(sw_sync_reg) + 32'd1, 32'(LED_W), 32'(gi));
    end
  endgenerate

  // Rotate left by rot_pos; with rot_pos=0 the right-shift term is empty.
  assign rot_back = 32'(LED_W) - 32'(rot_pos_reg);
  assign rotated  = (base << rot_pos_reg) | (base >> rot_back);

  // Transform mux feeding the output register.
  always_comb begin
    led_next = base;
    unique case (mode_reg)
      MODE_STATIC: led_next = base;
      MODE_SHIFT:  led_next = base >> 2;
      MODE_ROTATE: led_next = rotated;
      MODE_BLINK:  led_next = phase_reg ? '0 : ~base;
      default:     led_next = base;
    endcase
  end

  // Registered LED drive.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      led_reg <= '0;
    end else begin
      led_reg <= led_next;
    end
  end

  assign led  = led_reg;
  assign mode = mode_reg;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl: an 8-LED and a 4-LED instance share
// the same switch, button and reset stimulus.
module tb_led_mode_ctrl;

  logic       clk_125 = 1'b0;
  logic       rst_n;
  logic [2:0] sw;
  logic [3:0] btn;
  logic [7:0] led8;
  logic [1:0] mode8;
  logic [3:0] led4;
  logic [1:0] mode4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rot_exp [9] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30,
                              8'h60, 8'hC0, 8'h81, 8'h03};

  always #5 clk_125 = ~clk_125;

  led_mode_ctrl #(
    .LED_W(8), .SW_W(3), .DEB_CYCLES(4), .STEP_CYCLES(5)
  ) dut (
    .clk_125(clk_125), .rst_n(rst_n), .sw(sw), .btn(btn),
    .led(led8), .mode(mode8)
  );

  led_mode_ctrl #(
    .LED_W(4), .SW_W(3), .DEB_CYCLES(4), .STEP_CYCLES(5)
  ) dut4 (
    .clk_125(clk_125), .rst_n(rst_n), .sw(sw), .btn(btn),
    .led(led4), .mode(mode4)
  );

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_125);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw    = 3'd2;
    btn   = 4'b0000;
    step(2);
    n_tests++;
    if (led8 !== 8'h00 || mode8 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_hold: led=%h mode=%0d expected led=00 mode=0", led8, mode8);
    end
    rst_n = 1'b1;
    step(1);
    $display("[TB] reset released, edge 1 led=%h", led8);
    n_tests++;
    if (led8 !== 8'h01) begin
      n_fail++;
      $display("FAIL reset_first_edge: led=%h expected 01", led8);
    end
    step(2);
    n_tests++;
    if (led8 !== 8'h07) begin
      n_fail++;
      $display("FAIL reset_sw_latency: led=%h expected 07", led8);
    end
    n_tests++;
    if (led4 !== 4'h7) begin
      n_fail++;
      $display("FAIL reset_sw_latency_w4: led=%h expected 7", led4);
    end
  endtask

  task automatic test_press_latency();
    sw  = 3'd7;
    btn = 4'b0010;
    step(7);
    n_tests++;
    if (mode8 !== 2'd0 || led8 !== 8'hFF) begin
      n_fail++;
      $display("FAIL press_edge6: mode=%0d led=%h expected mode=0 led=ff", mode8, led8);
    end
    step(1);
    n_tests++;
    if (mode8 !== 2'd1) begin
      n_fail++;
      $display("FAIL press_mode_edge7: mode=%0d expected 1", mode8);
    end
    step(1);
    $display("[TB] btn[1] press, edge 8 mode=%0d led=%h", mode8, led8);
    n_tests++;
    if (led8 !== 8'h3F) begin
      n_fail++;
      $display("FAIL press_led_edge8: led=%h expected 3f", led8);
    end
    step(1);
    btn = 4'b0000;
    step(10);
  endtask

  task automatic test_glitch();
    btn = 4'b0001;
    step(3);
    btn = 4'b0000;
    step(12);
    $display("[TB] btn[0] 3-cycle glitch, mode=%0d", mode8);
    n_tests++;
    if (mode8 !== 2'd1) begin
      n_fail++;
      $display("FAIL glitch_reject: mode=%0d expected 1", mode8);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    $display("[TB] mid-cycle reset, led=%h mode=%0d", led8, mode8);
    n_tests++;
    if (led8 !== 8'h00 || mode8 !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: led=%h mode=%0d expected led=00 mode=0", led8, mode8);
    end
    step(1);
    rst_n = 1'b1;
    step(1);
    n_tests++;
    if (led8 !== 8'h01) begin
      n_fail++;
      $display("FAIL async_reset_release: led=%h expected 01", led8);
    end
    step(4);
  endtask

  task automatic test_simultaneous();
    btn = 4'b1100;
    step(8);
    $display("[TB] btn[3:2] together, mode=%0d", mode8);
    n_tests++;
    if (mode8 !== 2'd3) begin
      n_fail++;
      $display("FAIL simultaneous_press: mode=%0d expected 3", mode8);
    end
    btn = 4'b0000;
    step(10);
    n_tests++;
    if (mode8 !== 2'd3) begin
      n_fail++;
      $display("FAIL release_no_effect: mode=%0d expected 3", mode8);
    end
  endtask

  task automatic test_rotate();
    sw = 3'd1;
    step(4);
    btn = 4'b0100;
    step(9);
    for (int j = 0; j < 9; j++) begin
      $display("[TB] rotate step %0d led=%h", j, led8);
      n_tests++;
      if (led8 !== rot_exp[j]) begin
        n_fail++;
        $display("FAIL rotate_step%0d: led=%h expected %h", j, led8, rot_exp[j]);
      end
      step(4);
      n_tests++;
      if (led8 !== rot_exp[j]) begin
        n_fail++;
        $display("FAIL rotate_hold%0d: led=%h expected %h", j, led8, rot_exp[j]);
      end
      step(1);
    end
    btn = 4'b0000;
    step(10);
  endtask

  task automatic test_blink();
    logic [7:0] exp_led;
    sw = 3'd0;
    step(4);
    btn = 4'b1000;
    step(9);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step(5);
      exp_led = (j % 2 == 0) ? 8'hFE : 8'h00;
      $display("[TB] blink step %0d led=%h", j, led8);
      n_tests++;
      if (led8 !== exp_led) begin
        n_fail++;
        $display("FAIL blink_step%0d: led=%h expected %h", j, led8, exp_led);
      end
    end
    btn = 4'b0000;
    step(8);
    // Re-press: the old timebase would show 00 twelve edges from here.
    btn = 4'b1000;
    step(9);
    n_tests++;
    if (led8 !== 8'hFE) begin
      n_fail++;
      $display("FAIL blink_restart: led=%h expected fe", led8);
    end
    step(4);
    $display("[TB] blink re-press, last edge of step led=%h", led8);
    n_tests++;
    if (led8 !== 8'hFE) begin
      n_fail++;
      $display("FAIL blink_restart_hold: led=%h expected fe", led8);
    end
    step(1);
    n_tests++;
    if (led8 !== 8'h00) begin
      n_fail++;
      $display("FAIL blink_restart_toggle: led=%h expected 00", led8);
    end
    btn = 4'b0000;
    step(10);
  endtask

  task automatic test_saturation();
    sw  = 3'd7;
    btn = 4'b0001;
    step(9);
    $display("[TB] w4 static sw=7 led=%h", led4);
    n_tests++;
    if (led4 !== 4'hF || mode4 !== 2'd0) begin
      n_fail++;
      $display("FAIL w4_saturate: led=%h mode=%0d expected led=f mode=0", led4, mode4);
    end
    n_tests++;
    if (led8 !== 8'hFF) begin
      n_fail++;
      $display("FAIL w8_static_sw7: led=%h expected ff", led8);
    end
    btn = 4'b0000;
    step(10);
    btn = 4'b0010;
    step(9);
    $display("[TB] w4 shift sw=7 led=%h", led4);
    n_tests++;
    if (led4 !== 4'h3 || mode4 !== 2'd1) begin
      n_fail++;
      $display("FAIL w4_shift: led=%h mode=%0d expected led=3 mode=1", led4, mode4);
    end
    btn = 4'b0000;
    step(2);
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_glitch();
    test_async_reset();
    test_simultaneous();
    test_rotate();
    test_blink();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
